wave_capture: RTL and testbench

Sample writer for the waveform path: accepts a stream of DATA_WIDTH samples over a valid/ready handshake and writes them into an internal 2**ADDRESS_WIDTH-entry circular RAM. It is the write side of the table-lookup path the sine generator reads from. Every accepted sample also produces a delayed readout taken `offset` samples back, which feeds the signal-delay datapath. A small FSM covers three things: one-shot versus continuous capture, stop/restart, and an optional clear pass.

---
 rtl/wave_pkg.sv | 17 +
 rtl/wave_ram.sv | 34 +++
 rtl/wave_capture.sv | 170 +++++++++++++++++
 tb/tb_wave_capture.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// wave_pkg: shared types and default widths for the waveform capture path.
//   cap_state_t  - capture FSM state encoding (2-bit)
//   WAVE_ADDR_W  - default RAM address width (depth = 2**WAVE_ADDR_W)
//   WAVE_DATA_W  - default sample width
package wave_pkg;

    localparam int WAVE_ADDR_W = 8;
    localparam int WAVE_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

endpackage

// File: rtl/wave_ram.sv
// wave_ram: simple dual-port synchronous RAM, one write port and one
// registered read port. A read and a write to the same address on the same
// edge return the old contents (read-before-write).
//   clk, rst_n       clock; async active-low reset (read register only,
//                    the array itself is never cleared)
//   we/waddr/wdata   write port
//   re/raddr         read enable/address; rdata updates only when re=1
//   rdata            registered read data
module wave_ram #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic [ADDRESS_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/wave_capture.sv
// wave_capture: sample writer for the waveform path. Accepts samples over
// valid/ready, writes them into a circular 2**ADDRESS_WIDTH-entry RAM and,
// per accept, returns the sample taken `offset` accepts back (offset 0 is a
// bypass of the incoming sample).
//   clk, rst_n          clock; async active-low reset
//   start, stop         capture control pulses (start wins)
//   continuous          1 = wrap forever, 0 = one pass of D samples
//   in_valid/in_data    sample stream; in_ready = state is CAPTURE
//   offset              readout delay in samples
//   out_valid, dout     delayed readout, 1 cycle after the accept
//   count, wrapped      samples since start (saturating), sticky wrap flag
//   done                state is DONE
// Build option: WAVE_CAPTURE_CLEAR_EN adds a CLEAR pass that zeroes the RAM
// after every start before capture begins.
module wave_capture
    import wave_pkg::*;
#(
    parameter int ADDRESS_WIDTH = WAVE_ADDR_W,
    parameter int DATA_WIDTH    = WAVE_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     continuous,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     in_ready,
    input  logic [ADDRESS_WIDTH-1:0] offset,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic [ADDRESS_WIDTH:0]   count,
    output logic                     wrapped,
    output logic                     done
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = {ADDRESS_WIDTH{1'b1}};
    localparam logic [ADDRESS_WIDTH:0]   DEPTH     = {1'b1, {ADDRESS_WIDTH{1'b0}}};
    localparam logic [ADDRESS_WIDTH:0]   CNT_LAST  = {1'b0, LAST_ADDR};
`ifdef WAVE_CAPTURE_CLEAR_EN
    localparam cap_state_t START_ST = CLEAR;
`else
    localparam cap_state_t START_ST = CAPTURE;
`endif

    cap_state_t              state, state_nx;
    logic [ADDRESS_WIDTH-1:0] wr_ptr;
    logic [ADDRESS_WIDTH:0]   cnt_q;
    logic                     wrap_q, cont_q;
    logic                     wr_acc, hist_ok, rd_fire;
    logic                     out_vld_q, byp_sel_q;
    logic [DATA_WIDTH-1:0]    byp_q, ram_q;
    logic                     ram_we;
    logic [ADDRESS_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0]    ram_wdata;
`ifdef WAVE_CAPTURE_CLEAR_EN
    logic [ADDRESS_WIDTH-1:0] clr_addr;
`endif

    assign in_ready = (state == CAPTURE);
    assign done     = (state == DONE);
    assign count    = cnt_q;
    assign wrapped  = wrap_q;

    // A sample accepted on a restart cycle is dropped: it belongs to the
    // capture being abandoned.
    assign wr_acc  = in_valid && in_ready && !start;
    assign hist_ok = (cnt_q >= {1'b0, offset});
    assign rd_fire = wr_acc && hist_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = START_ST;
            CAPTURE: begin
                if (start)     state_nx = START_ST;
                else if (stop) state_nx = DONE;
                else if (wr_acc && !cont_q && cnt_q == CNT_LAST) state_nx = DONE;
            end
`ifdef WAVE_CAPTURE_CLEAR_EN
            CLEAR: begin
                if (start)                       state_nx = CLEAR;
                else if (stop)                   state_nx = DONE;
                else if (clr_addr == LAST_ADDR)  state_nx = CAPTURE;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            cont_q <= 1'b0;
        end else if (start) begin
            wr_ptr <= '0;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            cont_q <= continuous;
        end else if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (cnt_q != DEPTH)       cnt_q  <= cnt_q + 1'b1;
            if (wr_ptr == LAST_ADDR)  wrap_q <= 1'b1;
        end
    end

`ifdef WAVE_CAPTURE_CLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               clr_addr <= '0;
        else if (start)           clr_addr <= '0;
        else if (state == CLEAR)  clr_addr <= clr_addr + 1'b1;
    end
`endif

    // Write port: captured samples, or zeros while the clear pass runs.
    always_comb begin
        ram_we    = wr_acc;
        ram_waddr = wr_ptr;
        ram_wdata = in_data;
`ifdef WAVE_CAPTURE_CLEAR_EN
        if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr;
            ram_wdata = '0;
        end
`endif
    end

    // Readout: offset 0 bypasses the RAM (the sample is not stored yet);
    // otherwise the RAM's registered port supplies the old sample. Both
    // sources only load on a qualified readout, so dout holds in between.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            byp_sel_q <= 1'b0;
            byp_q     <= '0;
        end else begin
            out_vld_q <= rd_fire;
            if (rd_fire) begin
                byp_sel_q <= (offset == '0);
                byp_q     <= in_data;
            end
        end
    end

    assign out_valid = out_vld_q;
    assign dout      = byp_sel_q ? byp_q : ram_q;

    wave_ram #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (rd_fire && (offset != '0)),
        .raddr (wr_ptr - offset),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_wave_capture.sv
// tb_wave_capture: directed self-checking bench for wave_capture (D=256).
module tb_wave_capture;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0, continuous = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic [7:0] offset = '0;
    logic       out_valid;
    logic [7:0] dout;
    logic [8:0] count;
    logic       wrapped, done;

    int n_chk = 0;
    int n_pass = 0;

    wave_capture #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .offset     (offset),
        .out_valid  (out_valid),
        .dout       (dout),
        .count      (count),
        .wrapped    (wrapped),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] dat(input int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    // Waits out the clear pass when that build option is enabled.
    task automatic wait_ready();
`ifdef WAVE_CAPTURE_CLEAR_EN
        int n = 0;
        while (!in_ready && n < 400) begin
            tick();
            n++;
        end
        chk("wait_ready_bound", int'(in_ready), 1);
`endif
    endtask

    task automatic do_start(input logic cont);
        continuous = cont;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_ready();
    endtask

    initial begin
        int acc, first_done;
        logic rdy;

        // ---- reset and abort mid-capture ----
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("idle_ready", int'(in_ready), 0);
        chk("idle_done", int'(done), 0);
        offset = 8'd0;
        do_start(1'b0);
        chk("cap_ready", int'(in_ready), 1);
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_count", int'(count), 5);
        chk("pre_rst_dout", int'(dout), 5);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", int'(in_ready), 0);
        chk("rst_oval", int'(out_valid), 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_wrapped", int'(wrapped), 0);
        chk("rst_done", int'(done), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", int'(in_ready), 0);

        // ---- delayed readout, offset 3 ----
        offset = 8'd3;
        do_start(1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(10 + i);
            tick();
            chk($sformatf("dly_oval%0d", i), int'(out_valid), (i >= 3) ? 1 : 0);
            if (i == 0) chk("dly_hold", int'(dout), 0);
            if (i == 3) chk("dly_dout3", int'(dout), 10);
            if (i == 4) chk("dly_dout4", int'(dout), 11);
        end
        in_valid = 1'b0;
        tick();
        chk("dly_pulse", int'(out_valid), 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_done", int'(done), 1);
        chk("stop_ready", int'(in_ready), 0);

        // ---- one-shot fill ----
        offset = 8'd0;
        do_start(1'b0);
        acc = 0;
        first_done = -1;
        for (int c = 0; c < 260; c++) begin
            in_valid = 1'b1;
            in_data  = 8'(c);
            rdy = in_ready;
            tick();
            if (rdy) acc++;
            if (done && first_done < 0) first_done = c;
        end
        in_valid = 1'b0;
        chk("fill_accepts", acc, 256);
        chk("fill_done_cycle", first_done, 255);
        chk("fill_count", int'(count), 256);
        chk("fill_done", int'(done), 1);
        chk("fill_ready", int'(in_ready), 0);

        // ---- bypass and continuous wrap ----
        offset = 8'd0;
        do_start(1'b1);
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1;
            in_data  = dat(i);
            tick();
            chk($sformatf("byp_dout%0d", i), int'(dout), int'(dat(i)));
            if (i == 254) chk("wrap_before", int'(wrapped), 0);
            if (i == 255) chk("wrap_after", int'(wrapped), 1);
        end
        chk("wrap_count", int'(count), 256);
        chk("wrap_ready", int'(in_ready), 1);
        // wr_ptr is now 44: offset 100 reads address 200, offset 255 then 46
        offset = 8'd100;
        in_data = dat(300);
        tick();
        chk("wrap_rd100_oval", int'(out_valid), 1);
        chk("wrap_rd100", int'(dout), int'(dat(200)));
        offset = 8'd255;
        in_data = dat(301);
        tick();
        chk("wrap_rd255", int'(dout), int'(dat(46)));

        // ---- priority: start with stop restarts, accept dropped ----
        offset = 8'd0;
        in_data = 8'h77;
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        in_valid = 1'b0;
        chk("prio_count", int'(count), 0);
        chk("prio_done", int'(done), 0);
        chk("prio_oval", int'(out_valid), 0);
        chk("prio_wrapped", int'(wrapped), 0);
        wait_ready();
        chk("prio_ready", int'(in_ready), 1);

        // ---- accept together with stop ----
        in_valid = 1'b1;
        in_data = 8'hA5;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        in_valid = 1'b0;
        chk("accstop_done", int'(done), 1);
        chk("accstop_ready", int'(in_ready), 0);
        chk("accstop_count", int'(count), 1);
        chk("accstop_oval", int'(out_valid), 1);
        chk("accstop_dout", int'(dout), 8'hA5);
        in_valid = 1'b1;
        in_data = 8'h3C;
        tick();
        in_valid = 1'b0;
        chk("after_done_count", int'(count), 1);
        chk("after_done_oval", int'(out_valid), 0);

`ifdef WAVE_CAPTURE_CLEAR_EN
        // ---- clear pass ----
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        begin
            int n = 0;
            offset = 8'd255;
            in_valid = 1'b1;
            in_data = 8'h09;
            start = 1'b1;
            tick();
            start = 1'b0;
            while (!in_ready && n < 400) begin
                tick();
                n++;
            end
            chk("clr_cycles", n, 256);
            tick();
            in_valid = 1'b0;
            chk("clr_count", int'(count), 1);
            chk("clr_dout", int'(dout), 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
